// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: merges two players' trail writes into one RAM port and owns the clear sweep.
// Optional FBARB_DROP_COUNT_EN enables the saturating dropped-request counter on drop_count.
module fb_write_arbiter #(
  parameter int unsigned         ADDR_W      = 19,
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         FB_DEPTH    = 307200,
  parameter logic [DATA_W-1:0]   CLEAR_VALUE = '0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              p2_wren,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [15:0]       drop_count
);

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                last_p2_q, last_p2_d;

  logic                h1_valid_q, h1_valid_d;
  logic [ADDR_W-1:0]   h1_addr_q, h1_addr_d;
  logic [DATA_W-1:0]   h1_data_q, h1_data_d;
  logic                h2_valid_q, h2_valid_d;
  logic [ADDR_W-1:0]   h2_addr_q, h2_addr_d;
  logic [DATA_W-1:0]   h2_data_q, h2_data_d;

  logic                ram_wren_d;
  logic [ADDR_W-1:0]   ram_wraddress_d;
  logic [DATA_W-1:0]   ram_data_d;
  logic                clear_busy_d;
  logic                clear_done_d;

  logic                run_c;
  logic                gnt1_c, gnt2_c;
  logic                p1_load_c, p2_load_c;
  logic [ADDR_W-1:0]   sweep_addr_c;

  // A clear request pre-empts arbitration in the cycle it is sampled.
  assign run_c  = (state_q == ST_RUN) && !clear_req;
  assign gnt1_c = run_c && h1_valid_q && (!h2_valid_q || last_p2_q);
  assign gnt2_c = run_c && h2_valid_q && !gnt1_c;

  assign p1_load_c = run_c && p1_wren && ({1'b0, p1_addr} < DEPTH_X) && (!h1_valid_q || gnt1_c);
  assign p2_load_c = run_c && p2_wren && ({1'b0, p2_addr} < DEPTH_X) && (!h2_valid_q || gnt2_c);

  // A restart inside the sweep writes address 0 in the same cycle.
  assign sweep_addr_c = clear_req ? '0 : sweep_q;

  // State and datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      sweep_q       <= '0;
      last_p2_q     <= 1'b1;
      h1_valid_q    <= 1'b0;
      h1_addr_q     <= '0;
      h1_data_q     <= '0;
      h2_valid_q    <= 1'b0;
      h2_addr_q     <= '0;
      h2_data_q     <= '0;
      ram_wren      <= 1'b0;
      ram_wraddress <= '0;
      ram_data      <= '0;
      clear_busy    <= 1'b1;
      clear_done    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      last_p2_q     <= last_p2_d;
      h1_valid_q    <= h1_valid_d;
      h1_addr_q     <= h1_addr_d;
      h1_data_q     <= h1_data_d;
      h2_valid_q    <= h2_valid_d;
      h2_addr_q     <= h2_addr_d;
      h2_data_q     <= h2_data_d;
      ram_wren      <= ram_wren_d;
      ram_wraddress <= ram_wraddress_d;
      ram_data      <= ram_data_d;
      clear_busy    <= clear_busy_d;
      clear_done    <= clear_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (!clear_req && sweep_q == LAST_ADDR) state_d = ST_RUN;
      ST_RUN:   if (clear_req) state_d = ST_CLEAR;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Output, sweep and holding-register next values
  always_comb begin
    ram_wren_d      = 1'b0;
    ram_wraddress_d = ram_wraddress;
    ram_data_d      = ram_data;
    clear_done_d    = 1'b0;
    sweep_d         = sweep_q;
    last_p2_d       = last_p2_q;
    h1_valid_d      = h1_valid_q;
    h1_addr_d       = h1_addr_q;
    h1_data_d       = h1_data_q;
    h2_valid_d      = h2_valid_q;
    h2_addr_d       = h2_addr_q;
    h2_data_d       = h2_data_q;

    unique case (state_q)
      ST_CLEAR: begin
        ram_wren_d      = 1'b1;
        ram_wraddress_d = sweep_addr_c;
        ram_data_d      = CLEAR_VALUE;
        if (!clear_req && sweep_q == LAST_ADDR) clear_done_d = 1'b1;
        else                                     sweep_d = sweep_addr_c + ADDR_W'(1);
      end
      ST_RUN: begin
        if (clear_req) begin
          sweep_d = '0;
        end else if (gnt1_c) begin
          ram_wren_d      = 1'b1;
          ram_wraddress_d = h1_addr_q;
          ram_data_d      = h1_data_q;
          last_p2_d       = 1'b0;
        end else if (gnt2_c) begin
          ram_wren_d      = 1'b1;
          ram_wraddress_d = h2_addr_q;
          ram_data_d      = h2_data_q;
          last_p2_d       = 1'b1;
        end
      end
      default: ;
    endcase

    // Drain on grant, then let a same-cycle load refill the slot.
    if (gnt1_c) h1_valid_d = 1'b0;
    if (gnt2_c) h2_valid_d = 1'b0;
    if (p1_load_c) begin
      h1_valid_d = 1'b1;
      h1_addr_d  = p1_addr;
      h1_data_d  = p1_data;
    end
    if (p2_load_c) begin
      h2_valid_d = 1'b1;
      h2_addr_d  = p2_addr;
      h2_data_d  = p2_data;
    end
    if (state_d == ST_CLEAR) begin
      h1_valid_d = 1'b0;
      h2_valid_d = 1'b0;
    end

    clear_busy_d = (state_d == ST_CLEAR);
  end

`ifdef FBARB_DROP_COUNT_EN
  logic        p1_drop_c, p2_drop_c;
  logic [16:0] drop_sum_c;

  assign p1_drop_c  = p1_wren && !p1_load_c;
  assign p2_drop_c  = p2_wren && !p2_load_c;
  assign drop_sum_c = 17'(drop_count) + 17'(p1_drop_c) + 17'(p2_drop_c);

  // Saturating drop counter; only reset clears it.
  always_ff @(posedge CLOCK_50) begin
    if (reset)                   drop_count <= '0;
    else if (drop_sum_c[16])     drop_count <= 16'hFFFF;
    else                         drop_count <= drop_sum_c[15:0];
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter with a shortened framebuffer depth.
module tb_fb_write_arbiter;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 2048;
  localparam logic [7:0]  CV     = 8'h3C;
`ifdef FBARB_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic              clear_req = 1'b0;
  logic              p1_wren = 1'b0;
  logic [ADDR_W-1:0] p1_addr = '0;
  logic [DATA_W-1:0] p1_data = '0;
  logic              p2_wren = 1'b0;
  logic [ADDR_W-1:0] p2_addr = '0;
  logic [DATA_W-1:0] p2_data = '0;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddress;
  logic [DATA_W-1:0] ram_data;
  logic              clear_busy;
  logic              clear_done;
  logic [15:0]       drop_count;

  int checks = 0;
  int errors = 0;

  fb_write_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(DEPTH), .CLEAR_VALUE(CV)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .clear_req(clear_req),
    .p1_wren(p1_wren), .p1_addr(p1_addr), .p1_data(p1_data),
    .p2_wren(p2_wren), .p2_addr(p2_addr), .p2_data(p2_data),
    .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_data(ram_data),
    .clear_busy(clear_busy), .clear_done(clear_done), .drop_count(drop_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ram(input string tag, input logic wren, input int addr, input logic [7:0] data);
    chk({tag, ".wren"}, 32'(ram_wren), 32'(wren));
    chk({tag, ".addr"}, 32'(ram_wraddress), 32'(addr));
    chk({tag, ".data"}, 32'(ram_data), 32'(data));
  endtask

  // Runs n sweep cycles starting at start_addr; mismatching cycles are tallied into one comparison.
  task automatic sweep_run(input string tag, input int start_addr, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      int a;
      logic last;
      tick();
      a = start_addr + i;
      last = (a == int'(DEPTH) - 1);
      if (ram_wren !== 1'b1 || ram_wraddress !== ADDR_W'(a) || ram_data !== CV ||
          clear_done !== last || clear_busy !== !last) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_ram("reset", 1'b0, 0, 8'h00);
    chk("reset.busy", 32'(clear_busy), 32'd1);
    chk("reset.done", 32'(clear_done), 32'd0);
    chk("reset.drops", 32'(drop_count), 32'd0);

    // Full sweep; one player request mid-sweep is a drop
    reset = 1'b0;
    sweep_run("sweep1.a", 0, 5);
    p1_wren = 1'b1; p1_addr = 19'd77; p1_data = 8'hEE;
    sweep_run("sweep1.b", 5, 1);
    p1_wren = 1'b0;
    sweep_run("sweep1.c", 6, int'(DEPTH) - 6);
    tick();
    chk_ram("idle1", 1'b0, int'(DEPTH) - 1, CV);
    chk("idle1.busy", 32'(clear_busy), 32'd0);
    chk("idle1.done", 32'(clear_done), 32'd0);
    chk("drops.clear", 32'(drop_count), DROP_EN ? 32'd1 : 32'd0);

    // Uncontended write: two edges of latency
    p1_wren = 1'b1; p1_addr = 19'd1000; p1_data = 8'h01;
    tick();
    p1_wren = 1'b0;
    chk("single.early", 32'(ram_wren), 32'd0);
    tick();
    chk_ram("single", 1'b1, 1000, 8'h01);
    tick();
    chk_ram("single.after", 1'b0, 1000, 8'h01);

    // Highest in-range address from p2; leaves p2 as last grant
    p2_wren = 1'b1; p2_addr = 19'd2047; p2_data = 8'h7F;
    tick();
    p2_wren = 1'b0;
    tick();
    chk_ram("p2.last_addr", 1'b1, 2047, 8'h7F);
    tick();

    // Two ties in a row: p1 first both times
    for (int r = 0; r < 2; r++) begin
      p1_wren = 1'b1; p1_addr = 19'd5; p1_data = 8'h01;
      p2_wren = 1'b1; p2_addr = 19'd6; p2_data = 8'h02;
      tick();
      p1_wren = 1'b0; p2_wren = 1'b0;
      chk("tie.early", 32'(ram_wren), 32'd0);
      tick();
      chk_ram($sformatf("tie%0d.first", r), 1'b1, 5, 8'h01);
      tick();
      chk_ram($sformatf("tie%0d.second", r), 1'b1, 6, 8'h02);
      tick();
      chk("tie.idle", 32'(ram_wren), 32'd0);
    end

    // Out-of-range address is dropped and never written
    p2_wren = 1'b1; p2_addr = 19'd2048; p2_data = 8'hAA;
    tick();
    p2_wren = 1'b0;
    chk("oor.e0", 32'(ram_wren), 32'd0);
    tick();
    chk("oor.e1", 32'(ram_wren), 32'd0);
    chk("drops.oor", 32'(drop_count), DROP_EN ? 32'd2 : 32'd0);

    // Both players held three cycles: one drop each, held contents kept
    p1_wren = 1'b1; p1_addr = 19'd10; p1_data = 8'h11;
    p2_wren = 1'b1; p2_addr = 19'd20; p2_data = 8'h21;
    tick();
    chk("held.e0", 32'(ram_wren), 32'd0);
    p1_data = 8'h12; p2_data = 8'h22;
    tick();
    chk_ram("held.e1", 1'b1, 10, 8'h11);
    p1_data = 8'h13; p2_data = 8'h23;
    tick();
    chk_ram("held.e2", 1'b1, 20, 8'h21);
    p1_wren = 1'b0; p2_wren = 1'b0;
    tick();
    chk_ram("held.e3", 1'b1, 10, 8'h12);
    tick();
    chk_ram("held.e4", 1'b1, 20, 8'h23);
    tick();
    chk("held.e5", 32'(ram_wren), 32'd0);
    chk("drops.held", 32'(drop_count), DROP_EN ? 32'd4 : 32'd0);

    // clear_req with p1 holding a pending write: flushed, sweep restarts
    p1_wren = 1'b1; p1_addr = 19'd30; p1_data = 8'h55;
    tick();
    p1_wren = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("creq.wren", 32'(ram_wren), 32'd0);
    chk("creq.busy", 32'(clear_busy), 32'd1);
    sweep_run("sweep2.a", 0, 100);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk_ram("restart", 1'b1, 0, CV);
    chk("restart.done", 32'(clear_done), 32'd0);
    sweep_run("sweep2.b", 1, int'(DEPTH) - 1);
    tick();
    chk_ram("idle2", 1'b0, int'(DEPTH) - 1, CV);
    chk("idle2.busy", 32'(clear_busy), 32'd0);
    tick();
    chk("flushed", 32'(ram_wren), 32'd0);
    chk("drops.kept", 32'(drop_count), DROP_EN ? 32'd4 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
